// File: rtl/syn_current_gen.sv
// Synaptic front end: weighted sum of presynaptic spikes accumulated into an
// 8-bit drive current that decays exponentially on a fixed tick.
module syn_current_gen #(
  parameter int N_IN         = 4,
  parameter int WIDTH        = 8,
  parameter int DECAY_SHIFT  = 3,
  parameter int DECAY_PERIOD = 4,
  localparam int AW = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int SW = WIDTH + $clog2(N_IN) + 1,
  localparam int CW = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IN-1:0]  spike_in,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_sat,
  output logic [WIDTH-1:0] current,
  output logic             active,
  output logic             sat
);

  localparam logic [SW-1:0] MAX_SUM  = {{(SW-WIDTH){1'b0}}, {WIDTH{1'b1}}};
  localparam logic [CW-1:0] CNT_LAST = CW'(DECAY_PERIOD - 1);

  logic [WIDTH-1:0] weight [N_IN];
  logic [CW-1:0]    cnt_p0;
  logic             tick_p0;
  logic [WIDTH-1:0] dec_p0;
  logic [WIDTH-1:0] base_p0;
  logic [SW-1:0]    sum_p0;
  logic             clamp_p0;
  logic [WIDTH-1:0] cur_p1;

  // A nonzero current always loses at least 1 per tick so the tail reaches 0.
  function automatic logic [WIDTH-1:0] decay_step(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] d;
    d = c >> DECAY_SHIFT;
    if (c != '0 && d == '0) d = WIDTH'(1);
    return d;
  endfunction

  function automatic logic [WIDTH-1:0] sat_clamp(input logic [SW-1:0] s);
    return (s > MAX_SUM) ? {WIDTH{1'b1}} : s[WIDTH-1:0];
  endfunction

  // Stage p0: decay tick, decay-then-accumulate on the registered current
  assign tick_p0 = (cnt_p0 == CNT_LAST);

  always_comb begin
    dec_p0   = decay_step(cur_p1);
    base_p0  = tick_p0 ? (cur_p1 - dec_p0) : cur_p1;
    sum_p0   = SW'(base_p0);
    for (int i = 0; i < N_IN; i++) begin
      if (spike_in[i]) sum_p0 = sum_p0 + SW'(weight[i]);
    end
    clamp_p0 = (sum_p0 > MAX_SUM);
  end

  // Stage p1: registered current, sticky saturation, weight file
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_p1 <= '0;
      sat    <= 1'b0;
      cnt_p0 <= '0;
      for (int i = 0; i < N_IN; i++) weight[i] <= '0;
    end else begin
      cnt_p0 <= tick_p0 ? '0 : cnt_p0 + CW'(1);
      cur_p1 <= sat_clamp(sum_p0);
      if (clamp_p0)     sat <= 1'b1;
      else if (clr_sat) sat <= 1'b0;
      // Spikes this cycle already read the old weight through sum_p0.
      if (wr_en && (int'(wr_addr) < N_IN)) weight[wr_addr] <= wr_data;
    end
  end

  assign current = cur_p1;
  assign active  = (cur_p1 != '0);

endmodule

// File: doc/syn_current_gen.md
Name: syn_current_gen

Overview:
Synaptic front end for the LIF neuron. Converts up to N_IN presynaptic spike lines into one 8-bit drive current, using a programmable weight per input. The synaptic current decays exponentially on a fixed tick. The `current` output connects directly to the neuron's `current` input, one stage upstream of `lif`.

Parameters:
N_IN, 4, number of presynaptic spike inputs (1..8)
WIDTH, 8, weight and current width
DECAY_SHIFT, 3, decay step is current >> DECAY_SHIFT
DECAY_PERIOD, 4, clock cycles between decay ticks (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low
spike_in  input  N_IN  presynaptic spikes, sampled each cycle, bit i selects weight i
wr_en  input  1  weight write strobe
wr_addr  input  clog2(N_IN) (min 1)  weight index to write
wr_data  input  WIDTH  weight value, unsigned
clr_sat  input  1  clears sticky saturation flag
current  output  WIDTH  registered synaptic current to neuron
active  output  1  high when current != 0 (combinational from the current register)
sat  output  1  sticky flag, set when an update clamps

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - current=0, sat=0, all weights=0, decay counter=0.
  - wr_en, spike_in and clr_sat are ignored in that cycle.
  - Reset mid-operation discards the accumulated current and all weights.
- Weights:
  - N_IN unsigned WIDTH-bit registers.
  - When wr_en=1 at an edge, weight[wr_addr] <= wr_data.
  - wr_addr >= N_IN is ignored.
  - A spike in the same cycle as a write uses the OLD weight. The new weight takes effect from the next cycle.
- Decay timer:
  - Counter runs 0..DECAY_PERIOD-1 and increments every cycle, wrapping to 0.
  - tick=1 in the cycle where counter==DECAY_PERIOD-1.
  - With DECAY_PERIOD=1, tick is high every cycle.
  - The first cycle after reset release has counter=0.
- Per-cycle update, registered:
  - dec = current >> DECAY_SHIFT.
  - If tick and current != 0 and dec == 0, dec = 1. This guarantees decay reaches 0.
  - base = tick ? current - dec : current.
  - sum = base + sum over i of (spike_in[i] ? weight[i] : 0). Compute at WIDTH+clog2(N_IN)+1 bits so no overflow occurs.
  - current <= min(sum, 2^WIDTH-1).
  - If sum > 2^WIDTH-1, set sat=1.
- Latency: a spike sampled at edge t is visible on `current` after edge t; one cycle, no combinational path from spike_in to current.
- Simultaneous decay and spikes: decay is applied first, then weights are added, all in the same cycle.
- sat behaviour:
  - Sticky: it stays high until clr_sat=1 or reset.
  - If clr_sat and a new clamp occur in the same cycle, set wins and sat=1.
- active follows current; it deasserts in the same cycle current becomes 0.
- No spikes and current=0: the state holds at 0 and only the counter advances.

Test Plan:
1. Reset dominance: rst_n=0 for 2 cycles with spike_in=4'hF, wr_en=1, wr_data=8'hFF → current=0, sat=0, active=0. After release, spike_in=4'hF still gives current=0 (weights 0).
2. Single spike and decay: write w0=40. Align so the spike lands at counter=0 and pulse spike_in=4'b0001 for one cycle → current=40,40,40,35 on the next four edges. Subsequent ticks give 31,28,25.
3. Saturation: w0..w3=200, spike_in=4'hF for one cycle → current=255, sat=1. sat stays 1 through decay. Pulse clr_sat → sat=0 while current keeps decaying (255→224 on next tick).
4. Small-tail decay: preload current=5 via w2=5 and one spike → on ticks current goes 5,4,3,2,1,0. active drops with the 0 value and current stays 0 afterwards.
5. Write/spike collision: w1=10, then one cycle with wr_en=1, wr_addr=1, wr_data=50, spike_in=4'b0010 → current increases by 10. The next spike on input 1 increases current by 50.
6. Decay plus spike same cycle: current=80 on a tick cycle with spike_in=4'b0010, w1=10 → current=80 (80-10+10). clr_sat and a clamping spike in the same cycle → sat=1.
